// File: rtl/gpioemu_pkg.sv
// Shared definitions for the gpioemu multiply initiator: register map,
// status encoding, job FSM states, bus phases and the per-state bus operation.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h037F;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;
  localparam logic [15:0] ADDR_RES  = 16'h0390;
  localparam logic [15:0] ADDR_CNT  = 16'h0398;

  localparam logic [1:0]  STATUS_DONE = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_A1,
    ST_WR_A2,
    ST_WR_GO,
    ST_POLL,
    ST_GAP,
    ST_RD_RES,
    ST_RD_CNT,
    ST_RESP
  } job_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } bus_phase_e;

  typedef struct packed {
    logic        is_rd;
    logic [15:0] addr;
    logic [31:0] wdata;
  } bus_op_t;

  // True for job states that own exactly one bus operation.
  function automatic logic is_bus_state(job_state_e s);
    return (s == ST_WR_A1) || (s == ST_WR_A2) || (s == ST_WR_GO) ||
           (s == ST_POLL)  || (s == ST_RD_RES) || (s == ST_RD_CNT);
  endfunction

  // Bus operation issued on behalf of a job state.
  function automatic bus_op_t op_for_state(job_state_e s, logic [23:0] a1, logic [23:0] a2);
    bus_op_t op;
    op = '{is_rd: 1'b0, addr: ADDR_A1, wdata: {8'h00, a1}};
    case (s)
      ST_WR_A2:  op = '{is_rd: 1'b0, addr: ADDR_A2,   wdata: {8'h00, a2}};
      ST_WR_GO:  op = '{is_rd: 1'b0, addr: ADDR_CTRL, wdata: 32'h0000_0001};
      ST_POLL:   op = '{is_rd: 1'b1, addr: ADDR_CTRL, wdata: 32'h0};
      ST_RD_RES: op = '{is_rd: 1'b1, addr: ADDR_RES,  wdata: 32'h0};
      ST_RD_CNT: op = '{is_rd: 1'b1, addr: ADDR_CNT,  wdata: 32'h0};
      default:   ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/gpioemu_bus_cycle.sv
// One gpioemu bus operation: SETUP (1 cycle) -> STROBE (STROBE_CYC cycles)
// -> HOLD (1 cycle). Address and write data are latched on start and stay
// constant for the whole operation; read data is captured on the last strobe
// cycle. A start seen during HOLD chains the next operation with no idle cycle.
module gpioemu_bus_cycle
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        is_rd,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] m_address,
  output logic        m_wr,
  output logic        m_rd,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYC - 1);

  bus_phase_e  phase;
  logic [CW-1:0] strobe_cnt;
  logic        is_rd_q;

  // Phase sequencer plus address/data/read-capture registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase      <= PH_IDLE;
      strobe_cnt <= '0;
      is_rd_q    <= 1'b0;
      m_address  <= '0;
      m_wdata    <= '0;
      rdata      <= '0;
    end else begin
      case (phase)
        PH_IDLE, PH_HOLD: begin
          if (start) begin
            phase     <= PH_SETUP;
            is_rd_q   <= is_rd;
            m_address <= addr;
            m_wdata   <= wdata;
          end else begin
            phase <= PH_IDLE;
          end
        end
        PH_SETUP: begin
          phase      <= PH_STROBE;
          strobe_cnt <= '0;
        end
        PH_STROBE: begin
          if (strobe_cnt == STROBE_LAST) begin
            phase <= PH_HOLD;
            if (is_rd_q) rdata <= m_rdata;
          end else begin
            strobe_cnt <= strobe_cnt + 1'b1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the phase register so reset drops them at once.
  assign m_rd = (phase == PH_STROBE) &&  is_rd_q;
  assign m_wr = (phase == PH_STROBE) && !is_rd_q;
  assign done = (phase == PH_HOLD);

endmodule

// File: rtl/gpioemu_mul_initiator.sv
// gpioemu multiply initiator: accepts a job (A1, A2), writes both operands and
// the start register, polls status until done, reads product and ones-count,
// and returns them on the response port.
// Optional feature: define GPIOEMU_POLL_TIMEOUT_EN to abort a job with
// rsp_err=1 after MAX_POLLS consecutive not-done status reads.
module gpioemu_mul_initiator
  import gpioemu_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int POLL_GAP   = 4
`ifdef GPIOEMU_POLL_TIMEOUT_EN
  ,
  parameter int MAX_POLLS  = 255
`endif
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_a1,
  input  logic [23:0] req_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [23:0] rsp_ones,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] m_address,
  output logic        m_wr,
  output logic        m_rd,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  job_state_e    state, state_next;
  logic [23:0]   a1_q, a2_q;
  logic [31:0]   result_q;
  logic [23:0]   ones_q;
  logic          kick_q;
  logic [GW-1:0] gap_cnt;

  logic          bus_start, bus_done;
  logic [31:0]   bus_rdata;
  bus_op_t       bus_op;

  logic          accept, status_done, gap_last, poll_not_done, poll_limit;

  assign accept        = (state == ST_IDLE) && req_valid;
  assign status_done   = (bus_rdata[1:0] == STATUS_DONE);
  assign gap_last      = (gap_cnt == '0);
  assign poll_not_done = (state == ST_POLL) && bus_done && !status_done;

  // Job state register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Job sequencing: each bus state advances when its operation completes.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = ST_WR_A1;
      ST_WR_A1:  if (bus_done)  state_next = ST_WR_A2;
      ST_WR_A2:  if (bus_done)  state_next = ST_WR_GO;
      ST_WR_GO:  if (bus_done)  state_next = ST_POLL;
      ST_POLL: begin
        if (bus_done) begin
          if (status_done)     state_next = ST_RD_RES;
          else if (poll_limit) state_next = ST_RESP;
          else                 state_next = ST_GAP;
        end
      end
      ST_GAP:    if (gap_last)  state_next = ST_POLL;
      ST_RD_RES: if (bus_done)  state_next = ST_RD_CNT;
      ST_RD_CNT: if (bus_done)  state_next = ST_RESP;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs and bus launch. A new operation is launched in the
  // first cycle after accept, in the HOLD of a chained operation, or in the
  // last gap cycle so the next poll's SETUP follows the gap directly.
  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    rsp_valid = (state == ST_RESP);
    bus_start = kick_q ||
                (bus_done && is_bus_state(state_next)) ||
                ((state == ST_GAP) && gap_last);
    bus_op    = op_for_state(state_next, a1_q, a2_q);
  end

  // Operand latch, response registers and first-operation kick.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_q     <= '0;
      a2_q     <= '0;
      result_q <= '0;
      ones_q   <= '0;
      kick_q   <= 1'b0;
    end else begin
      kick_q <= accept;
      if (accept) begin
        a1_q     <= req_a1;
        a2_q     <= req_a2;
        result_q <= '0;
        ones_q   <= '0;
      end
      if ((state == ST_RD_RES) && bus_done) result_q <= bus_rdata;
      if ((state == ST_RD_CNT) && bus_done) ones_q   <= bus_rdata[23:0];
    end
  end

  // Idle cycles between a not-done status read and the next poll.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      gap_cnt <= '0;
    end else if (poll_not_done) begin
      gap_cnt <= GW'(POLL_GAP - 1);
    end else if ((state == ST_GAP) && !gap_last) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

`ifdef GPIOEMU_POLL_TIMEOUT_EN
  logic [7:0] poll_cnt;
  logic       err_q;

  assign poll_limit = (poll_cnt == 8'(MAX_POLLS - 1));

  // Consecutive not-done status reads for the running job.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)           poll_cnt <= '0;
    else if (accept)        poll_cnt <= '0;
    else if (poll_not_done) poll_cnt <= poll_cnt + 1'b1;
  end

  // Abort flag, set when the poll budget runs out.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                       err_q <= 1'b0;
    else if (accept)                    err_q <= 1'b0;
    else if (poll_not_done && poll_limit) err_q <= 1'b1;
  end

  assign rsp_err = err_q;
`else
  assign poll_limit = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  assign rsp_result = result_q;
  assign rsp_ones   = ones_q;

  gpioemu_bus_cycle #(
    .STROBE_CYC(STROBE_CYC)
  ) u_bus (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (bus_start),
    .is_rd    (bus_op.is_rd),
    .addr     (bus_op.addr),
    .wdata    (bus_op.wdata),
    .done     (bus_done),
    .rdata    (bus_rdata),
    .m_address(m_address),
    .m_wr     (m_wr),
    .m_rd     (m_rd),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

endmodule

// File: tb/tb_gpioemu_mul_initiator.sv
// Self-checking bench for gpioemu_mul_initiator with a behavioural gpioemu
// slave, a bus monitor and a timing/result reference model.
module tb_gpioemu_mul_initiator;

  localparam int STROBE_CYC = 2;
  localparam int POLL_GAP   = 4;
  localparam int MAX_POLLS  = 255;
  localparam int OP_CYC     = STROBE_CYC + 2;
  localparam int BASE_LAT   = 6 * OP_CYC + 1;
  localparam int POLL_EXTRA = POLL_GAP + OP_CYC;
  localparam int LIMIT      = 5000;

  localparam logic [15:0] A_A1   = 16'h037F;
  localparam logic [15:0] A_A2   = 16'h0388;
  localparam logic [15:0] A_CTRL = 16'h03A0;
  localparam logic [15:0] A_RES  = 16'h0390;
  localparam logic [15:0] A_CNT  = 16'h0398;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_a1 = '0;
  logic [23:0] req_a2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [23:0] rsp_ones;
  logic        rsp_err;
  logic        busy;
  logic [15:0] m_address;
  logic        m_wr;
  logic        m_rd;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  gpioemu_mul_initiator #(
    .STROBE_CYC(STROBE_CYC),
    .POLL_GAP  (POLL_GAP)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a1    (req_a1),
    .req_a2    (req_a2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_ones  (rsp_ones),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .m_address (m_address),
    .m_wr      (m_wr),
    .m_rd      (m_rd),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference arithmetic: low 32 bits of the 48-bit product.
  function automatic logic [31:0] prod32(logic [23:0] a, logic [23:0] b);
    logic [47:0] p;
    p = {24'h0, a} * {24'h0, b};
    return p[31:0];
  endfunction

  // The slave model reports the ones-count of the product low word.
  function automatic logic [23:0] ones_of(logic [31:0] p);
    return 24'($countones(p));
  endfunction

  // ---------------- behavioural gpioemu slave ----------------
  logic [23:0] s_a1 = '0;
  logic [23:0] s_a2 = '0;
  int          s_polls = 0;
  int          nd_polls = 0;
  logic [1:0]  nd_status = 2'b01;

  always @(posedge m_wr) begin
    case (m_address)
      A_A1:   s_a1 = m_wdata[23:0];
      A_A2:   s_a2 = m_wdata[23:0];
      A_CTRL: if (m_wdata == 32'h1) s_polls = 0;
      default: ;
    endcase
  end

  always @(posedge m_rd) begin
    case (m_address)
      A_CTRL: begin
        m_rdata = (s_polls < nd_polls) ? {30'h0, nd_status} : 32'h3;
        s_polls++;
      end
      A_RES:   m_rdata = prod32(s_a1, s_a2);
      A_CNT:   m_rdata = {8'h00, ones_of(prod32(s_a1, s_a2))};
      default: m_rdata = 32'hDEAD_BEEF;
    endcase
  end

  // ---------------- bus monitor ----------------
  typedef struct {
    bit          wr;
    logic [15:0] addr;
    int          cyc;
  } op_t;

  op_t         ops[$];
  int          cyc_no = 0;
  int          strobe_len = 0;
  logic [15:0] strobe_addr = '0;

  always @(negedge n_reset) strobe_len = 0;

  always @(posedge clk) begin
    cyc_no++;
    if (n_reset) begin
      if (m_rd || m_wr) begin
        if (strobe_len == 0) begin
          strobe_addr = m_address;
          ops.push_back('{wr: m_wr, addr: m_address, cyc: cyc_no});
        end else begin
          checks++;
          if (m_address !== strobe_addr) begin
            errors++;
            $display("FAIL addr_stable: got %h required %h", m_address, strobe_addr);
          end
        end
        checks++;
        if (m_rd && m_wr) begin
          errors++;
          $display("FAIL strobe_overlap: m_rd=%b m_wr=%b required not both high", m_rd, m_wr);
        end
        strobe_len++;
      end else if (strobe_len != 0) begin
        checks++;
        if (strobe_len != STROBE_CYC) begin
          errors++;
          $display("FAIL strobe_width: got %0d required %0d", strobe_len, STROBE_CYC);
        end
        strobe_len = 0;
      end
    end
  end

  function automatic int count_ops(bit wr, logic [15:0] addr);
    int n = 0;
    foreach (ops[i]) if (ops[i].wr == wr && ops[i].addr == addr) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Offers one job from an idle DUT and waits (bounded) for rsp_valid.
  // lat counts clock edges from the accept edge to rsp_valid.
  task automatic run_job(input logic [23:0] a1, input logic [23:0] a2,
                         input int nd, input logic [1:0] nds,
                         output logic [31:0] res, output logic [23:0] ones,
                         output logic err, output int lat);
    nd_polls  = nd;
    nd_status = nds;
    @(negedge clk);
    req_a1    = a1;
    req_a2    = a2;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a1    = 24'($urandom);
    req_a2    = 24'($urandom);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (rsp_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", lat);
    end
    res  = rsp_result;
    ones = rsp_ones;
    err  = rsp_err;
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, busy, rsp_valid, rsp_err, m_rd, m_wr} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 100000",
               {req_ready, busy, rsp_valid, rsp_err, m_rd, m_wr});
    end
    checks++;
    if ({m_address, m_wdata, rsp_result, rsp_ones} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h result=%h ones=%h required all 0",
               m_address, m_wdata, rsp_result, rsp_ones);
    end
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, busy, m_rd, m_wr} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 1000", {req_ready, busy, m_rd, m_wr});
    end
  endtask

  task automatic test_basic();
    logic [31:0] res; logic [23:0] ones; logic err; int lat;
    run_job(24'd3, 24'd5, 0, 2'b01, res, ones, err, lat);
    checks++;
    if (res !== 32'd15) begin
      errors++; $display("FAIL basic_result: got %0d required 15", res);
    end
    checks++;
    if (ones !== ones_of(32'd15) || err !== 1'b0) begin
      errors++; $display("FAIL basic_ones_err: got ones=%0d err=%b required ones=%0d err=0",
                         ones, err, ones_of(32'd15));
    end
    checks++;
    if (lat != BASE_LAT) begin
      errors++; $display("FAIL basic_latency: got %0d required %0d", lat, BASE_LAT);
    end
    checks++;
    if ({busy, req_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_busy: got busy=%b req_ready=%b required 1/0", busy, req_ready);
    end
    finish_rsp();
    checks++;
    if ({busy, req_ready, rsp_valid} !== 3'b010) begin
      errors++; $display("FAIL basic_release: got %b required 010", {busy, req_ready, rsp_valid});
    end
  endtask

  task automatic test_max_trace();
    logic [31:0] res; logic [23:0] ones; logic err; int lat;
    bit          exp_wr[6];
    logic [15:0] exp_addr[6];
    exp_wr   = '{1, 1, 1, 0, 0, 0};
    exp_addr = '{A_A1, A_A2, A_CTRL, A_CTRL, A_RES, A_CNT};
    ops.delete();
    run_job(24'hFFFFFF, 24'hFFFFFF, 0, 2'b00, res, ones, err, lat);
    checks++;
    if (res !== 32'hFE00_0001 || ones !== 24'd8) begin
      errors++; $display("FAIL max_result: got %h/%0d required fe000001/8", res, ones);
    end
    checks++;
    if (ops.size() != 6) begin
      errors++; $display("FAIL trace_len: got %0d ops required 6", ops.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ops[i].wr != exp_wr[i] || ops[i].addr !== exp_addr[i]) begin
          errors++;
          $display("FAIL trace_op%0d: got wr=%0d addr=%h required wr=%0d addr=%h",
                   i, ops[i].wr, ops[i].addr, exp_wr[i], exp_addr[i]);
        end
      end
    end
    finish_rsp();
  endtask

  task automatic test_multi_poll();
    logic [31:0] res; logic [23:0] ones; logic err; int lat;
    int polls[$];
    ops.delete();
    run_job(24'h00ABCD, 24'h000123, 3, 2'b01, res, ones, err, lat);
    checks++;
    if (res !== prod32(24'h00ABCD, 24'h000123) || ones !== ones_of(prod32(24'h00ABCD, 24'h000123))) begin
      errors++; $display("FAIL multi_result: got %h/%0d", res, ones);
    end
    checks++;
    if (lat != BASE_LAT + 3 * POLL_EXTRA) begin
      errors++; $display("FAIL multi_latency: got %0d required %0d", lat, BASE_LAT + 3 * POLL_EXTRA);
    end
    foreach (ops[i]) if (!ops[i].wr && ops[i].addr == A_CTRL) polls.push_back(ops[i].cyc);
    checks++;
    if (polls.size() != 4) begin
      errors++; $display("FAIL multi_poll_count: got %0d required 4", polls.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (polls[i] - polls[i-1] != POLL_EXTRA) begin
          errors++; $display("FAIL poll_spacing%0d: got %0d required %0d",
                             i, polls[i] - polls[i-1], POLL_EXTRA);
        end
      end
    end
    finish_rsp();
  endtask

  task automatic test_random();
    logic [31:0] res; logic [23:0] ones; logic err; int lat;
    logic [23:0] a1, a2; int nd; logic [1:0] nds; int exp_lat;
    for (int n = 0; n < 8; n++) begin
      a1  = 24'($urandom);
      a2  = 24'($urandom);
      nd  = int'($urandom_range(0, 3));
      nds = 2'($urandom_range(0, 2));
      exp_lat = BASE_LAT + nd * POLL_EXTRA;
      run_job(a1, a2, nd, nds, res, ones, err, lat);
      checks++;
      if (res !== prod32(a1, a2) || ones !== ones_of(prod32(a1, a2)) || err !== 1'b0 || lat != exp_lat) begin
        errors++;
        $display("FAIL random%0d: a1=%h a2=%h got %h/%0d/%b lat %0d required %h/%0d/0 lat %0d",
                 n, a1, a2, res, ones, err, lat, prod32(a1, a2), ones_of(prod32(a1, a2)), exp_lat);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      finish_rsp();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic [23:0] ones; logic err; int lat;
    logic [23:0] b1, b2;
    run_job(24'h000777, 24'h000999, 0, 2'b00, res, ones, err, lat);
    b1 = 24'h12_3456;
    b2 = 24'h00_0042;
    @(negedge clk);
    req_a1 = b1;
    req_a2 = b2;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== res || rsp_ones !== ones || rsp_err !== err ||
          req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable%0d: valid=%b result=%h ones=%h ready=%b busy=%b required 1/%h/%h/0/1",
                 i, rsp_valid, rsp_result, rsp_ones, req_ready, busy, res, ones);
      end
    end
    checks++;
    if (res !== prod32(24'h000777, 24'h000999)) begin
      errors++; $display("FAIL hold_result: got %h required %h", res, prod32(24'h000777, 24'h000999));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL handshake_cycle: got %b required 100", {req_ready, busy, rsp_valid});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a1 = 24'($urandom);
    checks++;
    if ({req_ready, busy} !== 2'b01) begin
      errors++; $display("FAIL next_accept: got ready=%b busy=%b required 0/1", req_ready, busy);
    end
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== prod32(b1, b2) || lat != BASE_LAT) begin
      errors++; $display("FAIL second_job: valid=%b result=%h lat %0d required 1/%h lat %0d",
                         rsp_valid, rsp_result, lat, prod32(b1, b2), BASE_LAT);
    end
    finish_rsp();
  endtask

  task automatic test_reset_midop();
    logic [31:0] res; logic [23:0] ones; logic err; int lat;
    int wait_cyc;
    nd_polls  = 2;
    nd_status = 2'b10;
    @(negedge clk);
    req_a1 = 24'h0000AA;
    req_a2 = 24'h0000BB;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_cyc = 0;
    while (!(m_rd === 1'b1 && m_address === A_CTRL) && wait_cyc < 200) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    checks++;
    if (m_rd !== 1'b1) begin
      errors++; $display("FAIL midop_reach_poll: m_rd=%b after %0d cycles required 1", m_rd, wait_cyc);
    end
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if ({m_rd, m_wr, busy, req_ready, rsp_valid} !== 5'b00010) begin
      errors++; $display("FAIL midop_reset: got %b required 00010", {m_rd, m_wr, busy, req_ready, rsp_valid});
    end
    @(negedge clk);
    n_reset = 1'b1;
    run_job(24'h00FEED, 24'h000321, 1, 2'b01, res, ones, err, lat);
    checks++;
    if (res !== prod32(24'h00FEED, 24'h000321) || err !== 1'b0 || lat != BASE_LAT + POLL_EXTRA) begin
      errors++; $display("FAIL after_reset_job: got %h err=%b lat %0d required %h err=0 lat %0d",
                         res, err, lat, prod32(24'h00FEED, 24'h000321), BASE_LAT + POLL_EXTRA);
    end
    finish_rsp();
  endtask

`ifdef GPIOEMU_POLL_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] res; logic [23:0] ones; logic err; int lat; int exp_lat;
    exp_lat = 1 + (3 + MAX_POLLS) * OP_CYC + (MAX_POLLS - 1) * POLL_GAP;
    ops.delete();
    run_job(24'h000011, 24'h000022, 100000, 2'b01, res, ones, err, lat);
    checks++;
    if (err !== 1'b1 || res !== 32'h0 || ones !== 24'h0) begin
      errors++; $display("FAIL timeout_rsp: got err=%b result=%h ones=%h required 1/0/0", err, res, ones);
    end
    checks++;
    if (count_ops(0, A_CTRL) != MAX_POLLS) begin
      errors++; $display("FAIL timeout_polls: got %0d required %0d", count_ops(0, A_CTRL), MAX_POLLS);
    end
    checks++;
    if (count_ops(0, A_RES) + count_ops(0, A_CNT) != 0) begin
      errors++; $display("FAIL timeout_skip_reads: got %0d result reads required 0",
                         count_ops(0, A_RES) + count_ops(0, A_CNT));
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL timeout_latency: got %0d required %0d", lat, exp_lat);
    end
    finish_rsp();
  endtask
`else
  task automatic test_long_poll();
    logic [31:0] res; logic [23:0] ones; logic err; int lat;
    ops.delete();
    run_job(24'h0F0F0F, 24'h000101, 20, 2'b10, res, ones, err, lat);
    checks++;
    if (err !== 1'b0 || res !== prod32(24'h0F0F0F, 24'h000101)) begin
      errors++; $display("FAIL long_poll_rsp: got err=%b result=%h required 0/%h",
                         err, res, prod32(24'h0F0F0F, 24'h000101));
    end
    checks++;
    if (count_ops(0, A_CTRL) != 21 || lat != BASE_LAT + 20 * POLL_EXTRA) begin
      errors++; $display("FAIL long_poll_count: got %0d polls lat %0d required 21 lat %0d",
                         count_ops(0, A_CTRL), lat, BASE_LAT + 20 * POLL_EXTRA);
    end
    finish_rsp();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_max_trace();
    test_multi_poll();
    test_random();
    test_back_to_back();
    test_reset_midop();
`ifdef GPIOEMU_POLL_TIMEOUT_EN
    test_timeout();
`else
    test_long_poll();
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
